uart_rx_buffered: RTL and testbench

Parametrised UART receiver with an integrated elastic output buffer. It is the successor to the fixed 8N1 receive path used ahead of the ALU. It adds configurable data width, parity, stop-bit count and bit period, error reporting, and a ready/valid FIFO so the consumer can stall without losing bytes. It sits between the board RX pin and the ALU command parser.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_buffered_fifo.sv | 48 ++++
 rtl/uart_rx_buffered.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receive path.
// Holds the parity and receiver-state encodings plus the frame length calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_buffered_fifo.sv
// fifo_sync: first-word fall-through FIFO, zero-latency read of the head; a push into a full FIFO
// is refused unless a pop happens in the same cycle; pop while empty is ignored.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Extra wrap bit: equal pointers mean empty, equal index with differing wrap means full.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver (configurable width/parity/stop) feeding a ready/valid FIFO; frame pushed at the final
// stop sample, visible one cycle later; consumer stalls via m_ready_i, new frames dropped when full.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rxd_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(frame_bits(DATA_W, PARITY, STOP_BITS));
  localparam parity_e PAR_MODE = parity_e'(PARITY[1:0]);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_clks
    $error("CLKS_PER_BIT must be >= 4");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic [1:0]        sync_q;
  logic              rxd_s;
  rx_state_e         state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_err_q;
  logic              stop_err_q;
  logic              frame_err_q;
  logic              parity_err_q;
  logic              overflow_q;
  logic              tick;
  logic              last_stop;
  logic              stop_bad;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  assign rxd_s     = sync_q[1];
  assign tick      = (baud_q == '0);
  assign last_stop = (state_q == STOP) && tick && (bit_q == BIT_W'(STOP_BITS - 1));
  assign stop_bad  = stop_err_q || !rxd_s;
  assign push      = last_stop && !stop_bad && !par_err_q;
  assign pop       = m_ready_i && !empty;

  assign m_valid_o    = !empty;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overflow_o   = overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], rxd_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= push && full && !pop;
      // Free-running baud counter; IDLE re-arms it at half a bit to land samples mid-bit.
      baud_q <= tick ? BAUD_W'(CLKS_PER_BIT - 1) : baud_q - 1'b1;
      case (state_q)
        IDLE: begin
          if (!rxd_s) begin
            state_q    <= START;
            baud_q     <= BAUD_W'(CLKS_PER_BIT / 2 - 1);
            bit_q      <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
          end
        end
        START: begin
          if (tick) state_q <= rxd_s ? IDLE : DATA;
        end
        DATA: begin
          if (tick) begin
            shift_q <= {rxd_s, shift_q[DATA_W-1:1]};
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_q   <= '0;
              state_q <= (PAR_MODE == NONE) ? STOP : PAR;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        PAR: begin
          if (tick) begin
            par_err_q <= ((^shift_q) ^ rxd_s) != (PAR_MODE == ODD);
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (last_stop) begin
            if (stop_bad) begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end else begin
              parity_err_q <= par_err_q;
              state_q      <= IDLE;
            end
          end else if (tick) begin
            stop_err_q <= !rxd_s;
            bit_q      <= bit_q + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo_sync #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (m_ready_i),
    .data_o  (m_data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench: default receiver (A) plus an even-parity receiver (B), both driven at 16 clocks per bit.
module tb_uart_rx_buffered;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rxd_a, rxd_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b;
  logic [2:0] cnt_a, cnt_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  uart_rx_buffered #(
    .DATA_W(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd_a),
    .m_data_o(data_a), .m_valid_o(vld_a), .m_ready_i(rdy_a), .count_o(cnt_a),
    .frame_err_o(fe_a), .parity_err_o(pe_a), .overflow_o(ov_a)
  );

  uart_rx_buffered #(
    .DATA_W(8), .CLKS_PER_BIT(16), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd_b),
    .m_data_o(data_b), .m_valid_o(vld_b), .m_ready_i(rdy_b), .count_o(cnt_b),
    .frame_err_o(fe_b), .parity_err_o(pe_b), .overflow_o(ov_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse counters and pop logs, sampled on the falling edge.
  int         fe_n = 0, pe_n = 0, ov_n = 0, fe_bn = 0, pe_bn = 0, ov_bn = 0;
  int         pop_n = 0, pop_bn = 0;
  logic [7:0] pop_log [256];
  logic [7:0] pop_b_last = 8'h00;

  always @(negedge clk) begin
    if (fe_a) fe_n++;
    if (pe_a) pe_n++;
    if (ov_a) ov_n++;
    if (fe_b) fe_bn++;
    if (pe_b) pe_bn++;
    if (ov_b) ov_bn++;
    if (vld_a && rdy_a && pop_n < 256) begin
      pop_log[pop_n] = data_a;
      pop_n++;
    end
    if (vld_b && rdy_b) begin
      pop_b_last = data_b;
      pop_bn++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input bit to_b, input logic v);
    if (to_b) rxd_b = v;
    else      rxd_a = v;
    cycles(16);
  endtask

  task automatic send_frame(input bit to_b, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    drive_bit(to_b, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(to_b, d[i]);
    if (has_par) drive_bit(to_b, par);
    drive_bit(to_b, stop);
  endtask

  logic [7:0] walk [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
  int base, fe0, pe0, ov0;

  initial begin
    rst_n = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    cycles(5);
    @(negedge clk);
    chk_eq("rst_valid", vld_a, 0);
    chk_eq("rst_count", cnt_a, 0);
    chk_eq("rst_data", data_a, 0);
    chk_eq("rst_flags", {fe_a, pe_a, ov_a}, 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(20);

    // Walking ones, consumer always ready.
    base = pop_n; fe0 = fe_n; pe0 = pe_n; ov0 = ov_n;
    for (int k = 0; k < 4; k++) begin
      send_frame(1'b0, walk[k], 1'b0, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b1);
    end
    cycles(20);
    chk_eq("walk_pops", pop_n - base, 4);
    for (int k = 0; k < 4; k++) chk_eq($sformatf("walk_data%0d", k), pop_log[base + k], walk[k]);
    chk_eq("walk_errs", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);

    // Short glitch must not start a frame.
    base = pop_n; fe0 = fe_n;
    rxd_a = 1'b0;
    cycles(4);
    rxd_a = 1'b1;
    cycles(48);
    @(negedge clk);
    chk_eq("glitch_count", cnt_a, 0);
    chk_eq("glitch_pops", pop_n - base, 0);
    chk_eq("glitch_fe", fe_n - fe0, 0);
    cycles(1);

    // Bad stop bit followed by a held-low line, then recovery.
    base = pop_n; fe0 = fe_n; pe0 = pe_n;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    @(negedge clk);
    chk_eq("ferr_pulses", fe_n - fe0, 1);
    chk_eq("ferr_perr", pe_n - pe0, 0);
    chk_eq("ferr_count", cnt_a, 0);
    chk_eq("ferr_pops", pop_n - base, 0);
    cycles(1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    cycles(10);
    chk_eq("recover_pops", pop_n - base, 1);
    chk_eq("recover_data", pop_log[base], 8'h3C);
    chk_eq("recover_fe", fe_n - fe0, 1);

    // Stall until full, overflow on the fifth frame, then drain.
    rdy_a = 1'b0;
    ov0 = ov_n;
    for (int k = 0; k < 4; k++) begin
      send_frame(1'b0, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1);
      drive_bit(1'b0, 1'b1);
    end
    @(negedge clk);
    chk_eq("stall_count4", cnt_a, 4);
    chk_eq("stall_no_ovf", ov_n - ov0, 0);
    cycles(1);
    send_frame(1'b0, 8'h14, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    @(negedge clk);
    chk_eq("ovf_count", cnt_a, 4);
    chk_eq("ovf_pulses", ov_n - ov0, 1);
    chk_eq("stall_head", data_a, 8'h10);
    cycles(30);
    @(negedge clk);
    chk_eq("stall_stable", data_a, 8'h10);
    chk_eq("stall_valid", vld_a, 1);
    base = pop_n;
    cycles(1);
    rdy_a = 1'b1;
    cycles(10);
    chk_eq("drain_pops", pop_n - base, 4);
    for (int k = 0; k < 4; k++) chk_eq($sformatf("drain_data%0d", k), pop_log[base + k], 8'h10 + 8'(k));
    @(negedge clk);
    chk_eq("drain_count", cnt_a, 0);
    cycles(1);

    // Reset in the middle of a frame with data buffered.
    rdy_a = 1'b0;
    send_frame(1'b0, 8'h42, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    @(negedge clk);
    chk_eq("pre_rst_count", cnt_a, 1);
    cycles(1);
    drive_bit(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive_bit(1'b0, 1'b1);
    cycles(8);
    rst_n = 1'b0;
    rxd_a = 1'b1;
    @(negedge clk);
    chk_eq("midrst_valid", vld_a, 0);
    chk_eq("midrst_count", cnt_a, 0);
    chk_eq("midrst_data", data_a, 0);
    chk_eq("midrst_flags", {fe_a, pe_a, ov_a}, 0);
    cycles(3);
    rst_n = 1'b1;
    rdy_a = 1'b1;
    cycles(20);
    base = pop_n;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    cycles(10);
    chk_eq("post_rst_pops", pop_n - base, 1);
    chk_eq("post_rst_data", pop_log[base], 8'h81);

    // Even parity on receiver B: 0x55 has four ones, so the correct parity bit is 0.
    base = pop_bn; pe0 = pe_bn; fe0 = fe_bn;
    send_frame(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    cycles(10);
    chk_eq("par_bad_pulse", pe_bn - pe0, 1);
    chk_eq("par_bad_pops", pop_bn - base, 0);
    chk_eq("par_bad_fe", fe_bn - fe0, 0);
    send_frame(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    cycles(10);
    chk_eq("par_ok_pops", pop_bn - base, 1);
    chk_eq("par_ok_data", pop_b_last, 8'h55);
    chk_eq("par_ok_pe", pe_bn - pe0, 1);
    chk_eq("par_b_ovf", ov_bn, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
